// File: rtl/uart_tx_ctrl.sv
// UART transmitter: 1 start bit, DATA_W data bits LSB first, 1 stop bit.
// Every bit is held for CLKS_PER_BIT clocks. tx, busy and done are registers.
module uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              bit_end;

   // A bit period ends on the edge where the baud counter sits at its last value.
   assign bit_end = (cnt_q == CNT_LAST);

   // Next-state logic; outputs are computed one edge ahead so they leave as registers.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            bit_d  = '0;
            tx_d   = 1'b1;
            busy_d = 1'b0;
            // Accepting edge: the start bit goes out immediately.
            if (start) begin
               shift_d = data_in;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = START;
            end
         end
         START: begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end) begin
               tx_d    = shift_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end) begin
               // Shift only at bit-period end; bit 1 becomes the next line value.
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  tx_d  = shift_q[1];
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         STOP: begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset forces an idle line immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a CLKS_PER_BIT=4 instance for the main scenarios and a
// CLKS_PER_BIT=2 instance for the short-bit boundary. Per-cycle expectations are
// queued as stimulus is driven and compared on the falling edge.
module tb_uart_tx_ctrl;

   logic       clk, rst;
   logic       start4, tx4, busy4, done4;
   logic [7:0] data4;
   logic       start2, tx2, busy2, done2;
   logic [7:0] data2;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit         sel;   // 0: CLKS_PER_BIT=4 instance, 1: CLKS_PER_BIT=2 instance
      logic [2:0] want;  // {tx, busy, done}
      string      tag;
   } rec_t;
   rec_t exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic [0:9] seq;   // line value per bit period, in send order
   } vec_t;
   vec_t vecs[6];

   uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .data_in(data4),
      .tx(tx4), .busy(busy4), .done(done4));

   uart_tx_ctrl #(.CLKS_PER_BIT(2), .DATA_W(8)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .data_in(data2),
      .tx(tx2), .busy(busy2), .done(done2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [2:0] got, input logic [2:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got tx/busy/done=%b expected %b at %0t", name, got, want, $time);
      end
   endfunction

   function automatic void push(input bit sel, input logic [2:0] want, input string tag);
      rec_t r;
      r.sel  = sel;
      r.want = want;
      r.tag  = tag;
      exp_q.push_back(r);
   endfunction

   // Scoreboard: one queued expectation is consumed per falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         rec_t r;
         r = exp_q.pop_front();
         if (r.sel) chk(r.tag, {tx2, busy2, done2}, r.want);
         else       chk(r.tag, {tx4, busy4, done4}, r.want);
      end
   end

   // Drive inputs for the next edge, then queue the output expected after it.
   task automatic step(input bit sel, input logic s, input logic [7:0] d,
                       input logic [2:0] want, input string tag);
      if (sel) begin start2 = s; data2 = d; end
      else     begin start4 = s; data4 = d; end
      @(posedge clk);
      #1;
      push(sel, want, tag);
   endtask

   // One full frame starting with an accepting edge; data_in switches to d1 after
   // 10 cycles and start stays at 'hold' after the accepting edge.
   task automatic frame(input bit sel, input logic [7:0] d0, input logic [0:9] seq,
                        input logic hold, input logic [7:0] d1, input string tag);
      int         cpb;
      logic       s;
      logic [7:0] d;
      cpb = sel ? 2 : 4;
      for (int k = 0; k <= 10 * cpb; k++) begin
         s = (k == 0) ? 1'b1 : hold;
         d = (k < 10) ? d0 : d1;
         if (k < 10 * cpb) step(sel, s, d, {seq[k / cpb], 2'b10}, tag);
         else              step(sel, s, d, 3'b101, {tag, "_done"});
      end
   endtask

   task automatic idle(input bit sel, input int n, input string tag);
      for (int i = 0; i < n; i++) step(sel, 1'b0, 8'h00, 3'b100, tag);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 10'b0101001011};
      vecs[1] = '{8'h00, 10'b0000000001};
      vecs[2] = '{8'hFF, 10'b0111111111};
      vecs[3] = '{8'h5A, 10'b0010110101};
      vecs[4] = '{8'h01, 10'b0100000001};
      vecs[5] = '{8'h81, 10'b0100000011};

      rst = 1'b0; start4 = 1'b0; data4 = 8'h00; start2 = 1'b0; data2 = 8'h00;
      #2 rst = 1'b1;
      #1 chk("reset_state4", {tx4, busy4, done4}, 3'b100);
      chk("reset_state2", {tx2, busy2, done2}, 3'b100);
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;

      idle(0, 50, "idle");

      // Table frames; data_in is inverted mid-frame and must not leak in.
      for (int i = 0; i < 6; i++) begin
         frame(0, vecs[i].data, vecs[i].seq, 1'b0, ~vecs[i].data, $sformatf("frame_%02h", vecs[i].data));
         idle(0, 3, "gap");
      end

      // start held high: second frame accepted on the edge after done, no gap.
      frame(0, 8'h3C, 10'b0001111001, 1'b1, 8'hFF, "b2b_3c");
      frame(0, 8'hFF, 10'b0111111111, 1'b0, 8'hFF, "b2b_ff");
      idle(0, 3, "b2b_tail");

      // Reset 17 cycles into a frame of 0x00: the line must idle at once.
      for (int k = 0; k <= 16; k++) step(0, k == 0, 8'h00, 3'b010, "abort_frame");
      @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("abort_async", {tx4, busy4, done4}, 3'b100);
      push(0, 3'b100, "abort_hold");
      idle(0, 3, "abort_hold");
      rst = 1'b0;
      idle(0, 45, "abort_no_done");
      frame(0, 8'h81, 10'b0100000011, 1'b0, 8'h00, "after_abort_81");
      idle(0, 2, "tail4");

      // Two-cycle bit period: 20-cycle frame, start bit low for 2 cycles only.
      idle(1, 2, "cpb2_idle");
      frame(1, 8'hFF, 10'b0111111111, 1'b0, 8'h00, "cpb2_ff");
      idle(1, 3, "cpb2_tail");

      @(negedge clk);
      #1 chk("sb_drained", {2'b00, exp_q.size() == 0}, 3'b001);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to transmit data_in; sampled on rising clk.
REQ-006 data_in  input  DATA_W  byte to send; sampled only on the accepting edge.
REQ-007 tx  output  1  serial line, idle high.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 done  output  1  single-cycle pulse at end of frame.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP, all registered.
REQ-011 In IDLE with start=1 on a rising edge, the block SHALL latch data_in into an internal DATA_W-bit shift register, clear the baud counter and bit counter, drive tx=0 and busy=1, and enter START on that same edge.
REQ-012 start SHALL be ignored while busy=1; data_in changes during a frame SHALL NOT affect the frame.
REQ-013 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0; a bit period ends on the edge where the counter equals CLKS_PER_BIT-1.
REQ-014 START: tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA with tx = shift register bit 0.
REQ-015 DATA: send DATA_W bits LSB first, each held exactly CLKS_PER_BIT cycles; shift register SHALL shift right only at bit-period end (enable-gated), bit counter increments there.
REQ-016 After bit DATA_W-1 period ends, enter STOP with tx=1 for exactly CLKS_PER_BIT cycles.
REQ-017 At end of STOP: state to IDLE, busy=0, done=1 for exactly one cycle, tx stays 1.
REQ-018 Frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles from the accepting edge to the edge that raises done.
REQ-019 start=1 in the cycle done=1 SHALL be accepted (state is IDLE), giving back-to-back frames with no extra idle bit.
REQ-020 tx, busy, done SHALL be driven directly from registers (glitch-free, no combinational path from inputs).
REQ-021 Unreachable state encodings SHALL return to IDLE on the next edge with tx=1.

Reset
REQ-022 rst=1 SHALL immediately (asynchronously) force state=IDLE, tx=1, busy=0, done=0, counters=0, shift register=0.
REQ-023 Reset mid-frame SHALL abort the frame; no done pulse is produced for the aborted frame.
REQ-024 After rst deasserts, the first start on a rising edge SHALL be accepted normally.

Verification (CLKS_PER_BIT=4, DATA_W=8)
REQ-025 Idle check: rst pulse, no start for 50 cycles -> tx=1, busy=0, done=0 throughout.
REQ-026 Single frame: start=1 one cycle with data_in=0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; done high exactly one cycle 40 cycles after accepting edge; busy high for those 40 cycles.
REQ-027 Busy ignore: start held high continuously with data_in=0x3C, data_in changed to 0xFF at cycle 10 -> first frame carries 0x3C; second frame (0xFF) starts on the done cycle, no gap.
REQ-028 Reset mid-frame: start with 0x00, assert rst at cycle 17 -> tx=1 and busy=0 within the same cycle, no done pulse; subsequent start with 0x81 sends 0,1,0,0,0,0,0,0,1,1.
REQ-029 Boundary: CLKS_PER_BIT=2, data_in=0xFF -> frame length 20 cycles, tx low only for the 2 start-bit cycles.
